// File: rtl/gas_sensor_tx.sv
// gas_sensor_tx: serial frame transmitter for the gas-detector link.
// Accepts 3-bit gas levels over valid/ready and shifts each one out MSB-first
// as a 12-bit frame {3'b110, level, seq[3:0], parity, 1'b0}, followed by an
// idle-low gap.
// Optional build macro GAS_SENSOR_TX_REPEAT_EN: heartbeat mode, where the last
// level is re-sent automatically whenever the block is idle and no new level
// is offered.
module gas_sensor_tx #(
  parameter int BIT_CYCLES = 1,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       arst,
  input  logic [2:0] lvl,
  input  logic       lvl_valid,
  output logic       lvl_ready,
  output logic       dout,
  output logic       busy,
  output logic       frame_done,
  output logic [3:0] frame_cnt
);

  localparam int MAXC = (BIT_CYCLES > GAP_CYCLES) ? BIT_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t        state_q, state_d;
  logic [10:0]   shift_q, shift_d;      // bits still to send after the one on dout
  logic [3:0]    bit_left_q, bit_left_d;
  logic [CW-1:0] cyc_q, cyc_d;          // cycles spent in the current bit / gap
  logic          dout_q, dout_d;
  logic          done_q, done_d;
  logic [3:0]    seq_q, seq_d;          // counter value the next frame will carry
  logic [3:0]    fcnt_q, fcnt_d;        // counter value of the last started frame
`ifdef GAS_SENSOR_TX_REPEAT_EN
  logic [2:0]    lvl_q, lvl_d;          // level of the last frame, for repeats
  logic          sent_q, sent_d;        // at least one frame since reset
`endif

  logic          start;
  logic [2:0]    start_lvl;
  logic [11:0]   frame_w;

  // Assemble a full frame: header, level, sequence, even parity, stop bit.
  function automatic logic [11:0] build_frame(input logic [2:0] l, input logic [3:0] c);
    return {3'b110, l, c, ^{l, c}, 1'b0};
  endfunction

  assign lvl_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign dout       = dout_q;
  assign frame_done = done_q;
  assign frame_cnt  = fcnt_q;

  // Next-state and output logic for the IDLE / SEND / GAP sequencer.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_left_d = bit_left_q;
    cyc_d      = cyc_q;
    dout_d     = dout_q;
    done_d     = 1'b0;
    seq_d      = seq_q;
    fcnt_d     = fcnt_q;
    start      = 1'b0;
    start_lvl  = lvl;
`ifdef GAS_SENSOR_TX_REPEAT_EN
    lvl_d      = lvl_q;
    sent_d     = sent_q;
`endif
    frame_w    = 12'd0;

    case (state_q)
      IDLE: begin
        dout_d = 1'b0;
        if (lvl_valid) begin
          start = 1'b1;
`ifdef GAS_SENSOR_TX_REPEAT_EN
        end else if (sent_q) begin
          start     = 1'b1;
          start_lvl = lvl_q;
`endif
        end
        if (start) begin
          frame_w    = build_frame(start_lvl, seq_q);
          dout_d     = frame_w[11];
          shift_d    = frame_w[10:0];
          bit_left_d = 4'd11;
          cyc_d      = '0;
          fcnt_d     = seq_q;
          seq_d      = seq_q + 4'd1;
          state_d    = SEND;
`ifdef GAS_SENSOR_TX_REPEAT_EN
          lvl_d      = start_lvl;
          sent_d     = 1'b1;
`endif
        end
      end
      SEND: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d = '0;
          if (bit_left_q == 4'd0) begin
            dout_d  = 1'b0;
            done_d  = 1'b1;
            state_d = GAP;
          end else begin
            dout_d     = shift_q[10];
            shift_d    = {shift_q[9:0], 1'b0};
            bit_left_d = bit_left_q - 4'd1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      GAP: begin
        dout_d = 1'b0;
        if (cyc_q == GAP_LAST) begin
          cyc_d   = '0;
          state_d = IDLE;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      default: begin
        dout_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Control registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q    <= IDLE;
      bit_left_q <= 4'd0;
      cyc_q      <= '0;
      dout_q     <= 1'b0;
      done_q     <= 1'b0;
      seq_q      <= 4'd0;
      fcnt_q     <= 4'd0;
`ifdef GAS_SENSOR_TX_REPEAT_EN
      sent_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_left_q <= bit_left_d;
      cyc_q      <= cyc_d;
      dout_q     <= dout_d;
      done_q     <= done_d;
      seq_q      <= seq_d;
      fcnt_q     <= fcnt_d;
`ifdef GAS_SENSOR_TX_REPEAT_EN
      sent_q     <= sent_d;
`endif
    end
  end

  // Data registers; only observed once the control path has loaded them.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
`ifdef GAS_SENSOR_TX_REPEAT_EN
    lvl_q   <= lvl_d;
`endif
  end

endmodule

// File: tb/tb_gas_sensor_tx.sv
// Testbench for gas_sensor_tx: randomized levels, a queue-based scoreboard fed
// by a frame-level reference model, and a decoupled serial-line monitor.
// A second instance with BIT_CYCLES=3 covers stretched bit timing.
module tb_gas_sensor_tx;

  localparam int MB = 1;
  localparam int MG = 2;
  localparam int B3 = 3;
  localparam int G3 = 2;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic [2:0] lvl = 3'd0;
  logic       lvl_valid = 1'b0;
  logic       lvl_ready, dout, busy, frame_done;
  logic [3:0] frame_cnt;

  logic [2:0] lvl3 = 3'b111;
  logic       lvl_valid3 = 1'b0;
  logic       lvl_ready3, dout3, busy3, frame_done3;
  logic [3:0] frame_cnt3;

  always #5 clk = ~clk;

  gas_sensor_tx #(.BIT_CYCLES(MB), .GAP_CYCLES(MG)) u_dut (
    .clk(clk), .arst(arst), .lvl(lvl), .lvl_valid(lvl_valid),
    .lvl_ready(lvl_ready), .dout(dout), .busy(busy),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  gas_sensor_tx #(.BIT_CYCLES(B3), .GAP_CYCLES(G3)) u_dut3 (
    .clk(clk), .arst(arst), .lvl(lvl3), .lvl_valid(lvl_valid3),
    .lvl_ready(lvl_ready3), .dout(dout3), .busy(busy3),
    .frame_done(frame_done3), .frame_cnt(frame_cnt3)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: frames as numbers, readiness as an edge index.
  typedef struct {
    logic [11:0] f;
    logic [3:0]  c;
  } exp_t;

  exp_t       q[$];
  int         e = 0;        // index of the next rising edge
  int         free_at = 0;  // first edge at which a new frame may start
  int         mcnt = 0;
  bit         msent = 0;
  logic [2:0] mlast = 3'd0;
  bit         chk_en = 0;

  function automatic logic [11:0] model_frame(input logic [2:0] l, input int c);
    logic [6:0] pbits;
    int p, v;
    pbits = {l, 4'(c)};
    p = $countones(pbits) % 2;
    v = 6 * 512 + int'(l) * 64 + c * 4 + p * 2;
    return 12'(v);
  endfunction

  task automatic push(input logic [2:0] l);
    exp_t x;
    x.f = model_frame(l, mcnt);
    x.c = 4'(mcnt);
    q.push_back(x);
    mcnt    = (mcnt + 1) % 16;
    msent   = 1;
    mlast   = l;
    free_at = e + 12 * MB + MG + 1;
  endtask

  // One clock of stimulus: check readiness, drive inputs, advance the model.
  task automatic step(input bit r, input bit v, input logic [2:0] l, input bit v3 = 1'b0);
    @(negedge clk);
    if (chk_en) chk("lvl_ready", {31'd0, lvl_ready}, {31'd0, (e >= free_at)});
    arst       = r;
    lvl_valid  = v;
    lvl        = l;
    lvl_valid3 = v3;
    if (r) begin
      mcnt    = 0;
      msent   = 0;
      free_at = 0;
      chk_en  = 1;
    end else if (e >= free_at) begin
      if (v) push(l);
`ifdef GAS_SENSOR_TX_REPEAT_EN
      else if (msent) push(mlast);
`endif
    end
    e++;
  endtask

  task automatic send(input logic [2:0] l);
    for (int k = 0; k < 100 && !(e >= free_at); k++) step(0, 0, 3'd0);
    step(0, 1, l);
  endtask

  // Monitor: decodes the serial line of the main instance against the queue.
  initial begin
    int   j;
    bit   coll;
    bit   mon_en;
    exp_t cur;
    j = 0; coll = 0; mon_en = 0;
    cur.f = '0; cur.c = '0;
    forever begin
      @(posedge clk); #1;
      if (arst === 1'b1) begin
        mon_en = 1;
        coll   = 0;
        chk("rst_dout",  {31'd0, dout}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_done",  {31'd0, frame_done}, 32'd0);
        chk("rst_ready", {31'd0, lvl_ready}, 32'd1);
        chk("rst_cnt",   {28'd0, frame_cnt}, 32'd0);
      end else if (mon_en) begin
        if (!coll) begin
          if (busy === 1'b1) begin
            chk("frame_expected", {31'd0, (q.size() > 0)}, 32'd1);
            if (q.size() > 0) begin
              cur  = q.pop_front();
              coll = 1;
              j    = 0;
              chk("frame_cnt", {28'd0, frame_cnt}, {28'd0, cur.c});
            end
          end else begin
            chk("idle_dout", {31'd0, dout}, 32'd0);
            chk("idle_done", {31'd0, frame_done}, 32'd0);
          end
        end
        if (coll) begin
          if (j < 12 * MB) begin
            chk("frame_bit",    {31'd0, dout}, {31'd0, cur.f[11 - j / MB]});
            chk("send_done",    {31'd0, frame_done}, 32'd0);
            chk("send_busy",    {31'd0, busy}, 32'd1);
          end else if (j < 12 * MB + MG) begin
            chk("gap_dout", {31'd0, dout}, 32'd0);
            chk("gap_done", {31'd0, frame_done}, {31'd0, (j == 12 * MB)});
            chk("gap_busy", {31'd0, busy}, 32'd1);
          end else begin
            chk("end_busy", {31'd0, busy}, 32'd0);
            chk("end_dout", {31'd0, dout}, 32'd0);
            coll = 0;
          end
          j++;
        end
      end
    end
  end

  // Stimulus sequence.
  initial begin
    logic [11:0] f3;

    step(1, 0, 3'd0);
    step(1, 0, 3'd0);

    // Directed: 3'b101 with counter 0, then 3'b011 with counter 1.
    send(3'b101);
    send(3'b011);

    // Random traffic with sparse valid.
    for (int k = 0; k < 300; k++)
      step(0, ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)));

    // Valid held high: back-to-back frames, counter wraps.
    for (int k = 0; k < 20 * 15 + 5; k++)
      step(0, 1, 3'($urandom_range(0, 7)));

    // Reset during bit 6 of a frame, with valid high in the reset cycle.
    send(3'($urandom_range(0, 7)));
    for (int k = 0; k < 5; k++) step(0, 0, 3'd0);
    step(1, 1, 3'b100);
    step(0, 1, 3'b010);
    for (int k = 0; k < 40; k++) step(0, 0, 3'd0);

    // Stretched bits on the second instance: 3'b111, counter 0.
    f3 = model_frame(3'b111, 0);
    step(0, 0, 3'd0, 1'b1);
    for (int j = 0; j < 38; j++) begin
      step(0, 0, 3'd0);
      if (j == 0) chk("b3_cnt", {28'd0, frame_cnt3}, 32'd0);
      if (j < 12 * B3) chk("b3_bit", {31'd0, dout3}, {31'd0, f3[11 - j / B3]});
      chk("b3_done", {31'd0, frame_done3}, {31'd0, (j == 12 * B3)});
    end

    step(0, 0, 3'd0);
    @(posedge clk); #2;
    chk("queue_drained", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
